// File: rtl/inst_fetch_responder.sv
// Instruction-memory fetch responder: valid/ready request and response
// channels, programmable wait states, one outstanding fetch, and a
// program-load write port that fills the word array.
module inst_fetch_responder #(
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_inst_o,
    output logic        rsp_err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [32:0] LIMIT    = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    logic [31:0]   mem [DEPTH];

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [31:0]   hold_inst_q, hold_inst_d;
    logic          hold_err_q, hold_err_d;
    logic [31:0]   rsp_inst_q, rsp_inst_d;
    logic          rsp_err_q, rsp_err_d;

    logic [AW-1:0] req_idx, load_idx;
    logic          req_err, accept, ready_raw;
    logic [31:0]   fetch_inst;

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_inst_o  = rsp_inst_q;
    assign rsp_err_o   = rsp_err_q;

    // Request decode, handshake and next-state logic. The response
    // registers only change on entry into RESP so they stay put while
    // rsp_valid_o is low; WAIT spends one extra edge after the counter
    // expires so the response rises WAIT_CYCLES+1 edges after accept.
    always_comb begin
        req_idx    = req_addr_i[AW+1:2];
        load_idx   = load_addr_i[AW+1:2];
        req_err    = (req_addr_i[1:0] != 2'b00) || ({1'b0, req_addr_i} >= LIMIT);
        fetch_inst = req_err ? NOP_INST : mem[req_idx];

        case (state_q)
            S_IDLE:  ready_raw = 1'b1;
            S_RESP:  ready_raw = rsp_ready_i;
            default: ready_raw = 1'b0;
        endcase
        // Reset forces ready low immediately, independent of the clock.
        req_ready_o = rst && ready_raw;
        accept      = req_valid_i && req_ready_o;

        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        hold_inst_d = hold_inst_q;
        hold_err_d  = hold_err_q;
        rsp_inst_d  = rsp_inst_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE, S_RESP: begin
                if ((state_q == S_RESP) && rsp_ready_i)
                    state_d = S_IDLE;
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        rsp_inst_d = fetch_inst;
                        rsp_err_d  = req_err;
                    end else begin
                        state_d     = S_WAIT;
                        cnt_d       = CNT_INIT;
                        last_d      = 1'b0;
                        hold_inst_d = fetch_inst;
                        hold_err_d  = req_err;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!last_q) begin
                    last_d = 1'b1;
                end else begin
                    state_d    = S_RESP;
                    rsp_inst_d = hold_inst_q;
                    rsp_err_d  = hold_err_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; reset drops any in-flight fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            last_q      <= 1'b0;
            hold_inst_q <= 32'd0;
            hold_err_q  <= 1'b0;
            rsp_inst_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            hold_inst_q <= hold_inst_d;
            hold_err_q  <= hold_err_d;
            rsp_inst_q  <= rsp_inst_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Program-load writes; contents survive reset. A same-edge fetch of the
    // same word sees the old value because the read above is sampled first.
    always_ff @(posedge clk) begin
        if (load_we_i && ({1'b0, load_addr_i} < LIMIT))
            mem[load_idx] <= load_data_i;
    end
endmodule
